proc_control_fsm: RTL and testbench
===================================

# proc_control_fsm

Control unit for the multicycle simple processor. It latches a 9-bit instruction from the DIN bus and steps through time slots T0–T3. In each slot it drives the one-hot register load/output enables, ALU controls and bus-source select for the R0–R7/A/G datapath. It is the sequencer that owns the shared bus and the 3-to-8 register-select decode.

## Interface
- No parameters: instruction width fixed at 9 bits (III XXX YYY), 8 registers.
- Clock  in  1  rising-edge clock for all state.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request; sampled only in T0.
- DIN  in  9  external data/instruction bus; loaded into IR when IRin=1.
- Done  out  1  one-cycle pulse in the final step of each instruction.
- IRin  out  1  IR load enable (informational; IR is internal).
- Rin  out  [0:7]  one-hot register load; Rin[0] (MSB position) = R0 … Rin[7] = R7.
- Rout  out  [0:7]  one-hot register bus drive, same ordering.
- Gout  out  1  G drives bus.
- DINout  out  1  DIN drives bus.
- Ain  out  1  load A from bus.
- Gin  out  1  load G with ALU result.
- AddSub  out  1  ALU op: 0 = add, 1 = subtract.

## Operation
- Internal state: 2-bit step counter Tstep (T0..T3), 9-bit IR. Opcode I = IR[8:6], X = IR[5:3], Y = IR[2:0].
- All outputs are combinational from (Tstep, IR, Run). Every output not listed for a step is 0.
- T0: IRin = Run. If Run=1, IR <= DIN and go to T1; else stay in T0.
- Opcode 000 mv Rx,Ry. T1: Rout[Y]=1, Rin[X]=1, Done=1. Next state T0.
- Opcode 001 mvi Rx,#D. T1: DINout=1, Rin[X]=1, Done=1. The immediate is on DIN this cycle. Next state T0.
- Opcode 010 add / 011 sub Rx,Ry:
  - T1: Rout[X]=1, Ain=1.
  - T2: Rout[Y]=1, Gin=1, AddSub=(I==011).
  - T3: Gout=1, Rin[X]=1, Done=1. Next state T0.
- Opcodes 100–111 are reserved. T1: Done=1 only, no enables. Next state T0.
- Bus exclusivity invariant: in any cycle, at most one of {any Rout bit, Gout, DINout} is 1. Rin and Rout are each zero or one-hot.
- X==Y is legal (mv R3,R3; add R2,R2 doubles R2). No special handling.
- Back-to-back: if Run is still 1 in the T0 following Done, the next instruction is fetched immediately. There is no idle cycle beyond T0.
- Run changes outside T0 are ignored. An instruction always completes unless reset.

## Timing
- Resetn low (asynchronous): Tstep <= T0, IR <= 0. All outputs forced to 0 while Resetn=0, including IRin regardless of Run.
- Reset release: first active edge is evaluated in T0.
- Latency from the T0 edge with Run=1 to Done:
  - mv/mvi/reserved: Done in the next cycle (2 cycles per instruction).
  - add/sub: Done 3 cycles later (4 cycles per instruction).
- Done is high for exactly one cycle per instruction and is never high in T0.
- Register writes via Rin take effect on the clock edge ending the step, so Rx updates on the edge that ends the Done cycle.
- Reset mid-instruction (any of T1–T3): abort immediately. Outputs go to 0 asynchronously, no Done, no partial Rin. Resume in T0.

## Test plan
- Reset and idle: Resetn=0 with Run=1 -> all outputs 0. Release with Run=0 for 5 cycles -> state stays T0, all outputs 0, IR unchanged.
- mvi: T0 with DIN=9'b001_000_000 and Run=1, then DIN=5 -> T1 has DINout=1, Rin=8'b10000000, Done=1. Next cycle is T0.
- mv: DIN=9'b000_001_000 (mv R1,R0) -> T1 has Rout=8'b10000000, Rin=8'b01000000, Done=1. No other outputs high.
- add then sub back-to-back with Run held at 1:
  - add R0,R1 -> T1: Rout[0], Ain. T2: Rout[1], Gin, AddSub=0. T3: Gout, Rin[0], Done.
  - The next T0 fetches sub R0,R1 -> T2 shows AddSub=1. Done is asserted on cycles 4 and 8.
- Reserved opcode 9'b111_010_101 -> T1 has Done=1, all enables 0. Check the bus-exclusivity assertion every cycle.
- Reset mid-add: assert Resetn=0 during T2 -> Gin drops with no clock edge and no Done. After release with Run=1, the next fetch decodes correctly.

Source files
------------

// File: rtl/proc_control_fsm.sv
// Sequencer for the multicycle R0-R7/A/G processor: fetches a 9-bit instruction
// (III XXX YYY) in T0 and issues datapath enables for steps T1..T3.
module proc_control_fsm (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Run,
   input  logic [8:0] DIN,
   output logic       Done,
   output logic       IRin,
   output logic [0:7] Rin,
   output logic [0:7] Rout,
   output logic       Gout,
   output logic       DINout,
   output logic       Ain,
   output logic       Gin,
   output logic       AddSub
);

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b011;

   logic [1:0] r_tstep;
   logic [1:0] w_tstep_nxt;
   logic [8:0] r_ir;
   logic [2:0] w_op;
   logic [0:7] w_x_sel;
   logic [0:7] w_y_sel;
   logic       w_alu_op;

   assign w_op     = r_ir[8:6];
   // Index 0 is the MSB of a [0:7] vector, so shifting right by the register number selects that register.
   assign w_x_sel  = 8'b1000_0000 >> r_ir[5:3];
   assign w_y_sel  = 8'b1000_0000 >> r_ir[2:0];
   assign w_alu_op = (w_op[2:1] == 2'b01);

   // Step counter register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_tstep <= T0;
      end else begin
         r_tstep <= w_tstep_nxt;
      end
   end

   // Instruction register, loaded only on a T0 fetch.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_ir <= 9'd0;
      end else if ((r_tstep == T0) && Run) begin
         r_ir <= DIN;
      end else begin
         r_ir <= r_ir;
      end
   end

   // Next-step selection: only add/sub run past T1.
   always_comb begin
      w_tstep_nxt = T0;
      case (r_tstep)
         T0:      w_tstep_nxt = Run ? T1 : T0;
         T1:      w_tstep_nxt = w_alu_op ? T2 : T0;
         T2:      w_tstep_nxt = T3;
         T3:      w_tstep_nxt = T0;
         default: w_tstep_nxt = T0;
      endcase
   end

   // Datapath control decode; everything is held low while Resetn is asserted.
   always_comb begin
      Done   = 1'b0;
      IRin   = 1'b0;
      Rin    = 8'b0000_0000;
      Rout   = 8'b0000_0000;
      Gout   = 1'b0;
      DINout = 1'b0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      AddSub = 1'b0;
      if (Resetn) begin
         case (r_tstep)
            T0: IRin = Run;
            T1: begin
               case (w_op)
                  OP_MV: begin
                     Rout = w_y_sel;
                     Rin  = w_x_sel;
                     Done = 1'b1;
                  end
                  OP_MVI: begin
                     DINout = 1'b1;
                     Rin    = w_x_sel;
                     Done   = 1'b1;
                  end
                  3'b010, OP_SUB: begin
                     Rout = w_x_sel;
                     Ain  = 1'b1;
                  end
                  default: Done = 1'b1;
               endcase
            end
            T2: begin
               if (w_alu_op) begin
                  Rout   = w_y_sel;
                  Gin    = 1'b1;
                  AddSub = (w_op == OP_SUB);
               end else begin
                  Gin = 1'b0;
               end
            end
            T3: begin
               if (w_alu_op) begin
                  Gout = 1'b1;
                  Rin  = w_x_sel;
                  Done = 1'b1;
               end else begin
                  Gout = 1'b0;
               end
            end
            default: IRin = 1'b0;
         endcase
      end else begin
         IRin = 1'b0;
      end
   end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Randomized scoreboard bench for proc_control_fsm: the driver queues the expected
// output word of every cycle it drives, and a negedge monitor pops and compares.
module tb_proc_control_fsm;

   logic       Clock;
   logic       Resetn;
   logic       Run;
   logic [8:0] DIN;
   logic       Done, IRin, Gout, DINout, Ain, Gin, AddSub;
   logic [0:7] Rin, Rout;

   int n_cmp = 0;
   int n_err = 0;
   logic [22:0] exp_q[$];
   logic [22:0] outv;

   proc_control_fsm dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN),
      .Done(Done), .IRin(IRin), .Rin(Rin), .Rout(Rout), .Gout(Gout),
      .DINout(DINout), .Ain(Ain), .Gin(Gin), .AddSub(AddSub)
   );

   assign outv = {Done, IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Output word: {Done, IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub}.
   function automatic logic [22:0] mk(input logic done, input logic irin,
                                      input logic [7:0] rin, input logic [7:0] rout,
                                      input logic gout, input logic dinout,
                                      input logic ain, input logic gin, input logic addsub);
      return {done, irin, rin, rout, gout, dinout, ain, gin, addsub};
   endfunction

   function automatic logic [7:0] reg_bit(input logic [2:0] r);
      logic [7:0] v;
      v = 8'd0;
      v[7 - r] = 1'b1;
      return v;
   endfunction

   function automatic int n_steps(input logic [8:0] ins);
      return (ins[8:6] == 3'd2 || ins[8:6] == 3'd3) ? 3 : 1;
   endfunction

   // Reference behaviour: what each instruction does on the bus in step k (1-based).
   function automatic logic [22:0] step_vec(input logic [8:0] ins, input int k);
      logic [7:0] rx, ry;
      rx = reg_bit(ins[5:3]);
      ry = reg_bit(ins[2:0]);
      case (ins[8:6])
         3'd0: return mk(1'b1, 1'b0, rx, ry, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         3'd1: return mk(1'b1, 1'b0, rx, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         3'd2, 3'd3: begin
            if (k == 1) return mk(1'b0, 1'b0, 8'd0, rx, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (k == 2) return mk(1'b0, 1'b0, 8'd0, ry, 1'b0, 1'b0, 1'b0, 1'b1, ins[6]);
            else return mk(1'b1, 1'b0, rx, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         default: return mk(1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
   endfunction

   task automatic check(input string name, input logic [22:0] act, input logic [22:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
      end
   endtask

   task automatic cycle(input logic run, input logic [8:0] din, input logic [22:0] e);
      @(posedge Clock);
      #1;
      Run = run;
      DIN = din;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      cycle(1'b0, 9'($urandom), 23'd0);
   endtask

   task automatic exec(input logic [8:0] ins, input logic [8:0] t1din);
      cycle(1'b1, ins, mk(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int k = 1; k <= n_steps(ins); k++) begin
         cycle(1'($urandom_range(0, 1)), (k == 1) ? t1din : 9'($urandom), step_vec(ins, k));
      end
   endtask

   // Monitor: bus exclusivity every live cycle, plus scoreboard compare.
   always @(negedge Clock) begin
      logic [22:0] e;
      if (Resetn) begin
         n_cmp++;
         if (($countones(Rout) + 32'(Gout) + 32'(DINout)) > 1 || $countones(Rin) > 1) begin
            n_err++;
            $display("FAIL bus_excl: Rout=%b Gout=%b DINout=%b Rin=%b", Rout, Gout, DINout, Rin);
         end
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs", outv, e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [8:0] add_ins;
      Resetn = 1'b0;
      Run    = 1'b1;
      DIN    = 9'b001_000_000;
      #3;
      check("reset_outputs", outv, 23'd0);
      @(posedge Clock);
      #1;
      Run    = 1'b0;
      Resetn = 1'b1;
      for (int i = 0; i < 5; i++) idle();

      exec(9'b001_000_000, 9'd5);
      idle();
      exec(9'b000_001_000, 9'($urandom));
      idle();
      exec(9'b010_000_001, 9'($urandom));
      exec(9'b011_000_001, 9'($urandom));
      idle();
      exec(9'b111_010_101, 9'($urandom));
      exec(9'b000_011_011, 9'($urandom));
      exec(9'b010_010_010, 9'($urandom));
      idle();

      // Abort an add in T2 and confirm outputs drop without a clock edge.
      add_ins = 9'b010_100_110;
      cycle(1'b1, add_ins, mk(1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cycle(1'b1, 9'($urandom), step_vec(add_ins, 1));
      @(posedge Clock);
      #2;
      check("midadd_t2", outv, step_vec(add_ins, 2));
      Resetn = 1'b0;
      #1;
      check("midadd_async_drop", outv, 23'd0);
      @(posedge Clock);
      #1;
      check("midadd_held", outv, 23'd0);
      Run    = 1'b0;
      Resetn = 1'b1;
      exec(9'b011_101_010, 9'($urandom));
      exec(9'b001_111_000, 9'($urandom));

      for (int n = 0; n < 80; n++) begin
         logic [8:0] ins;
         ins = 9'($urandom);
         exec(ins, 9'($urandom));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
      end
      idle();
      idle();
      @(negedge Clock);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
